axi4_w_buffer_gated: RTL

// - Write-data counterpart of the RAB read-data buffer. Buffers AXI4 W beats from the slave side and

---
 rtl/axi4_w_buffer_gated.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi4_w_buffer_gated.sv
// -----------------------------------------------------------------------------
// axi4_w_buffer_gated
//
// Write-data buffer that sits between the slave port and the master port,
// alongside the AW path. W beats are accepted upstream as long as there is
// room. They are released downstream only while at least one AW burst has
// been issued on the master side and its W data is not yet complete. This
// lets W lead AW upstream while keeping AW-before-W ordering downstream.
//
// Handshake semantics (both W ports): a beat transfers on a rising edge
// where valid & ready are both high. Valid, once raised, holds with a stable
// payload until the transfer. Ready never depends combinationally on valid.
//
// Ports
//   axi4_aclk, axi4_arst : clock, asynchronous active-high reset
//   s_axi4_w*            : slave-side W channel (into the buffer)
//   m_axi4_w*            : master-side W channel (FIFO head)
//   aw_issued            : one-cycle pulse per master-side AW handshake
//   aw_credit            : high while another AW may be issued
// -----------------------------------------------------------------------------
module axi4_w_buffer_gated #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_USER_WIDTH  = 4,
  parameter int BUFFER_DEPTH    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arst,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                        s_axi4_wlast,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  input  logic                        s_axi4_wvalid,
  output logic                        s_axi4_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic                        m_axi4_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
  output logic                        m_axi4_wvalid,
  input  logic                        m_axi4_wready,
  input  logic                        aw_issued,
  output logic                        aw_credit
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int WORD_WIDTH = AXI_USER_WIDTH + AXI_DATA_WIDTH + STRB_WIDTH + 1;
  localparam int PTR_WIDTH  = $clog2(BUFFER_DEPTH);
  localparam int FILL_WIDTH = PTR_WIDTH + 1;
  localparam int CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);

  // Storage word layout: {user, data, strb, last}
  logic [WORD_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [WORD_WIDTH-1:0] mem_d [BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_WIDTH-1:0] fill_q, fill_d;
  logic [CNT_WIDTH-1:0]  bursts_q, bursts_d;

  logic push;
  logic pop;
  logic burst_inc;
  logic burst_dec;

  // Ready comes only from the registered fill, so a simultaneous pop never
  // makes room for a push in the same cycle.
  assign s_axi4_wready = (fill_q != FILL_FULL);
  assign push          = s_axi4_wvalid & s_axi4_wready;

  // Gate on outstanding AW bursts. The head cannot lose its gate before it
  // pops: bursts only drops on a wlast pop, so valid stays up once raised.
  assign m_axi4_wvalid = (fill_q != '0) & (bursts_q != '0);
  assign pop           = m_axi4_wvalid & m_axi4_wready;

  // Master side always shows the storage word at the read pointer; with
  // storage cleared on reset this reads as zero until the first push.
  assign {m_axi4_wuser, m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast} = mem_q[rd_ptr_q];

  assign burst_inc = aw_issued;
  assign burst_dec = pop & m_axi4_wlast;
  assign aw_credit = (bursts_q < CNT_MAX);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    bursts_d = bursts_q;

    if (push) begin
      mem_d[wr_ptr_q] = {s_axi4_wuser, s_axi4_wdata, s_axi4_wstrb, s_axi4_wlast};
      // Depth is a power of two, so pointer overflow is the wrap.
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_WIDTH'(1);
      2'b01:   fill_d = fill_q - FILL_WIDTH'(1);
      default: fill_d = fill_q;
    endcase

    // Over-issue at the limit is a protocol error; hold at the limit.
    if (burst_inc && !burst_dec) begin
      if (bursts_q != CNT_MAX) begin
        bursts_d = bursts_q + CNT_WIDTH'(1);
      end
    end else if (burst_dec && !burst_inc) begin
      bursts_d = bursts_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      bursts_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      bursts_q <= bursts_d;
    end
  end

  // The AW path must honour aw_credit; an issue at the limit is an error.
  aw_over_issue: assert property (@(posedge axi4_aclk) disable iff (axi4_arst)
    !(aw_issued && (bursts_q == CNT_MAX)));

endmodule
